// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter between the CPU memory port (C) and a secondary master (D) onto one
// shared memory/IO bus, with registered ready pulses and a timeout for silent slaves.
module mio_bus_arbiter #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       TIMEOUT    = 16,
    parameter logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_D, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              last_d, last_d_next;
    logic              pick_c, pick_d;
    logic              m_req_next, m_we_next;
    logic [ADDR_W-1:0] m_addr_next;
    logic [DATA_W-1:0] m_wdata_next, c_rdata_next, d_rdata_next;
    logic              c_ready_next, d_ready_next, timeout_next;
    logic [1:0]        grant_next;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        last_d_next  = last_d;
        m_req_next   = m_req;
        m_we_next    = m_we;
        m_addr_next  = m_addr;
        m_wdata_next = m_wdata;
        c_rdata_next = c_rdata;
        d_rdata_next = d_rdata;
        c_ready_next = 1'b0;
        d_ready_next = 1'b0;
        grant_next   = grant;
        timeout_next = timeout_err;
        // on contention the port that was not served last wins
        pick_c       = c_req && (!d_req || last_d);
        pick_d       = d_req && (!c_req || !last_d);

        case (state)
            IDLE: begin
                if (pick_c) begin
                    state_next   = BUSY_C;
                    m_req_next   = 1'b1;
                    m_we_next    = c_we;
                    m_addr_next  = c_addr;
                    m_wdata_next = c_wdata;
                    grant_next   = 2'b01;
                    last_d_next  = 1'b0;
                    cnt_next     = '0;
                end else if (pick_d) begin
                    state_next   = BUSY_D;
                    m_req_next   = 1'b1;
                    m_we_next    = d_we;
                    m_addr_next  = d_addr;
                    m_wdata_next = d_wdata;
                    grant_next   = 2'b10;
                    last_d_next  = 1'b1;
                    cnt_next     = '0;
                end
            end
            BUSY_C, BUSY_D: begin
                // an ack on the last allowed cycle still counts as a normal completion
                if (m_ack || cnt == CNT_LAST) begin
                    state_next   = DONE;
                    m_req_next   = 1'b0;
                    grant_next   = '0;
                    timeout_next = timeout_err | ~m_ack;
                    if (state == BUSY_C) begin
                        c_ready_next = 1'b1;
                        c_rdata_next = m_ack ? m_rdata : ABORT_DATA;
                    end else begin
                        d_ready_next = 1'b1;
                        d_rdata_next = m_ack ? m_rdata : ABORT_DATA;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_d      <= 1'b1;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            c_rdata     <= '0;
            d_rdata     <= '0;
            c_ready     <= 1'b0;
            d_ready     <= 1'b0;
            grant       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            last_d      <= last_d_next;
            m_req       <= m_req_next;
            m_we        <= m_we_next;
            m_addr      <= m_addr_next;
            m_wdata     <= m_wdata_next;
            c_rdata     <= c_rdata_next;
            d_rdata     <= d_rdata_next;
            c_ready     <= c_ready_next;
            d_ready     <= d_ready_next;
            grant       <= grant_next;
            timeout_err <= timeout_next;
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios then random traffic,
// compared against a transaction-level model of arbitration, latching, completion and timeout.
module tb_mio_bus_arbiter;

    localparam int unsigned TO    = 16;
    localparam logic [31:0] ABORT = 32'hDEADBEEF;

    logic        clk, reset;
    logic        c_req, c_we, c_ready, d_req, d_we, d_ready;
    logic [31:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ack, timeout_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    // transaction-level model state
    bit          last_d;
    bit          err_m;
    logic [31:0] c_rd_m, d_rd_m;
    bit          c_known, d_known;

    mio_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ABORT_DATA(ABORT)
    ) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_d  = 1'b1;
        err_m   = 1'b0;
        c_rd_m  = '0;
        d_rd_m  = '0;
        c_known = 1'b1;
        d_known = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_m_req"}, m_req, 0);
        chk({tag, "_m_we"}, m_we, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
        chk({tag, "_c_rdata"}, c_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_c_ready"}, c_ready, 0);
        chk({tag, "_d_ready"}, d_ready, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_req"}, m_req, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_c_ready"}, c_ready, 0);
        chk({tag, "_d_ready"}, d_ready, 0);
        chk({tag, "_timeout_err"}, timeout_err, err_m);
        if (c_known) chk({tag, "_c_rdata"}, c_rdata, c_rd_m);
        if (d_known) chk({tag, "_d_rdata"}, d_rdata, d_rd_m);
    endtask

    task automatic req_c(input logic we, input logic [31:0] a, input logic [31:0] wd);
        c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd;
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    // One arbitration round starting at a negedge in IDLE with requests already driven.
    // w = number of BUSY cycles without ack before the ack cycle; w >= TO never acks.
    task automatic run_round(input int w, input bit fix_rd, input logic [31:0] rd_fix);
        bit          win_c, aborted;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wdata, rd, exp_rd;
        if (!c_req && !d_req) begin
            m_ack = 1'($urandom_range(0, 1)); m_rdata = $urandom;
            @(negedge clk);
            chk_quiet("idle");
            m_ack = 1'b0;
            return;
        end
        win_c     = c_req && (!d_req || last_d);
        last_d    = !win_c;
        exp_we    = win_c ? c_we : d_we;
        exp_addr  = win_c ? c_addr : d_addr;
        exp_wdata = win_c ? c_wdata : d_wdata;
        m_ack = 1'($urandom_range(0, 1)); m_rdata = $urandom;
        @(negedge clk);
        chk("grant", grant, win_c ? 2'b01 : 2'b10);
        chk("grant_m_req", m_req, 1);
        chk("grant_m_we", m_we, exp_we);
        chk("grant_m_addr", m_addr, exp_addr);
        chk("grant_m_wdata", m_wdata, exp_wdata);
        rd = '0;
        for (int k = 0; k < int'(TO); k++) begin
            if (win_c) begin c_addr = $urandom; c_wdata = $urandom; c_we = 1'($urandom_range(0, 1)); end
            else       begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1)); end
            m_ack = (k == w);
            rd = fix_rd ? rd_fix : $urandom;
            m_rdata = rd;
            @(negedge clk);
            if (k == w || k == int'(TO) - 1) break;
            chk("busy_m_req", m_req, 1);
            chk("busy_m_we", m_we, exp_we);
            chk("busy_m_addr", m_addr, exp_addr);
            chk("busy_m_wdata", m_wdata, exp_wdata);
            chk("busy_grant", grant, win_c ? 2'b01 : 2'b10);
            chk("busy_c_ready", c_ready, 0);
            chk("busy_d_ready", d_ready, 0);
        end
        aborted = (w >= int'(TO));
        exp_rd  = aborted ? ABORT : rd;
        if (aborted) err_m = 1'b1;
        if (win_c) begin
            c_known = !exp_we || aborted;
            c_rd_m  = exp_rd;
        end else begin
            d_known = !exp_we || aborted;
            d_rd_m  = exp_rd;
        end
        chk("done_c_ready", c_ready, win_c);
        chk("done_d_ready", d_ready, !win_c);
        chk("done_m_req", m_req, 0);
        chk("done_grant", grant, 0);
        chk("done_timeout_err", timeout_err, err_m);
        if (c_known) chk("done_c_rdata", c_rdata, c_rd_m);
        if (d_known) chk("done_d_rdata", d_rdata, d_rd_m);
        if (win_c) c_req = 1'b0; else d_req = 1'b0;
        m_ack = 1'($urandom_range(0, 1)); m_rdata = $urandom;
        @(negedge clk);
        chk_quiet("post");
        m_ack = 1'b0;
    endtask

    initial begin
        int sel, w;
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        reset = 1'b0;

        // reset in the middle of a CPU access
        req_c(1'b1, 32'h0000_0100, 32'h5555_AAAA);
        @(negedge clk);
        chk("mid_grant", grant, 2'b01);
        chk("mid_m_req", m_req, 1);
        @(negedge clk);
        reset = 1'b1; c_req = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        reset = 1'b0;
        model_reset();
        req_c(1'b0, $urandom, $urandom);
        req_d(1'b0, $urandom, $urandom);
        run_round(0, 0, '0);
        run_round(1, 0, '0);

        // single CPU read
        req_c(1'b0, 32'h0000_0040, $urandom);
        run_round(0, 1, 32'h1234_5678);

        // continuous contention
        repeat (4) begin
            if (!c_req) req_c(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!d_req) req_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            run_round(0, 0, '0);
        end
        run_round(0, 0, '0);

        // write latching with wait states
        req_d(1'b1, 32'h8000_0000, 32'hCAFE_F00D);
        run_round(3, 0, '0);

        // ack on the last allowed cycle, then a real timeout, then a good access
        req_c(1'b0, $urandom, $urandom);
        run_round(int'(TO) - 1, 0, '0);
        req_c(1'b0, $urandom, $urandom);
        run_round(int'(TO) + 4, 0, '0);
        req_d(1'b0, $urandom, $urandom);
        run_round(1, 0, '0);

        repeat (80) begin
            if (!c_req && $urandom_range(0, 2) != 0) req_c(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!d_req && $urandom_range(0, 2) != 0) req_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       w = int'($urandom_range(0, 4));
            else if (sel == 7) w = int'(TO) - 1;
            else if (sel == 8) w = int'(TO) - 2;
            else               w = int'(TO) + int'($urandom_range(0, 3));
            run_round(w, 0, '0);
        end

        // reset clears the sticky error
        reset = 1'b1; c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk_reset("rst_end");
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
